// File: rtl/decode_issue_stage.sv
// Decode/issue stage: immediate generation, one-entry valid/ready slot and a per-register scoreboard.
// Define DECODE_PERF_EN to add the saturating perf_issued / perf_stall counters.
module decode_issue_stage #(
   parameter int XLEN      = 36,
   parameter int NREGS     = 32,
   parameter int IMM_TYPES = 9,
   localparam int RA       = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic [XLEN-1:0]  pc_plus_4,
   input  logic [3:0]       imm_type,
   input  logic [RA-1:0]    rs1_addr,
   input  logic [RA-1:0]    rs2_addr,
   input  logic [RA-1:0]    rd_addr,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic             rd_write,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic [XLEN-1:0]  out_pc_plus_4,
   output logic [XLEN-1:0]  out_imm,
   output logic [RA-1:0]    out_rd_addr,
   output logic             out_rd_write,
   input  logic             wb_valid,
   input  logic [RA-1:0]    wb_addr,
   input  logic             flush,
   output logic [NREGS-1:0] pending
`ifdef DECODE_PERF_EN
   ,
   output logic [31:0]      perf_issued,
   output logic [31:0]      perf_stall
`endif
);

   // Handshake: a transfer happens on a cycle where valid && ready are both high;
   // ready never depends on valid of the same side.
   logic             r_valid;
   logic [31:0]      r_inst;
   logic [XLEN-1:0]  r_pc_plus_4;
   logic [XLEN-1:0]  r_imm;
   logic [RA-1:0]    r_rd_addr;
   logic             r_rd_write;
   logic [NREGS-1:0] r_pending;
   logic [NREGS-1:0] w_pending_nxt;
   logic [XLEN-1:0]  w_imm;
   logic             w_busy_rs1;
   logic             w_busy_rs2;
   logic             w_busy_rd;
   logic             w_hazard;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_drain;

   always_comb begin
      w_imm = '0;
      if (int'(imm_type) < IMM_TYPES) begin
         case (imm_type)
            4'd0:    w_imm = XLEN'(inst[24:0]);
            4'd1:    w_imm = XLEN'($signed({inst[24:20], inst[15:0]}));
            4'd2:    w_imm = XLEN'($signed(inst[21:0]));
            4'd3:    w_imm = XLEN'($signed(inst[14:0]));
            4'd4:    w_imm = XLEN'($signed(inst[18:0]));
            4'd5:    w_imm = XLEN'($signed({inst[24:20], inst[9:0]}));
            4'd6:    w_imm = XLEN'($signed(inst[14:4]));
            4'd7:    w_imm = XLEN'($signed({inst[24:20], inst[14:4]}));
            4'd8:    w_imm = XLEN'($signed({inst[24:20], inst[9:4]}));
            default: w_imm = '0;
         endcase
      end
   end

   // A register is busy while pending (unless retiring this cycle) or while the slot will write it.
   assign w_busy_rs1 = (r_pending[rs1_addr] && !(wb_valid && wb_addr == rs1_addr)) ||
                       (r_valid && r_rd_write && r_rd_addr == rs1_addr);
   assign w_busy_rs2 = (r_pending[rs2_addr] && !(wb_valid && wb_addr == rs2_addr)) ||
                       (r_valid && r_rd_write && r_rd_addr == rs2_addr);
   assign w_busy_rd  = (r_pending[rd_addr] && !(wb_valid && wb_addr == rd_addr)) ||
                       (r_valid && r_rd_write && r_rd_addr == rd_addr);

   assign w_hazard   = (rs1_used && w_busy_rs1) || (rs2_used && w_busy_rs2) || (rd_write && w_busy_rd);
   assign w_in_ready = !flush && !w_hazard && (!r_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_drain    = r_valid && out_ready && !flush;

   always_comb begin
      w_pending_nxt = r_pending;
      if (wb_valid) w_pending_nxt[wb_addr] = 1'b0;
      if (w_drain && r_rd_write) w_pending_nxt[r_rd_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_inst      <= '0;
         r_pc_plus_4 <= '0;
         r_imm       <= '0;
         r_rd_addr   <= '0;
         r_rd_write  <= 1'b0;
         r_pending   <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (flush) begin
            r_valid <= 1'b0;
         end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_inst      <= inst;
            r_pc_plus_4 <= pc_plus_4;
            r_imm       <= w_imm;
            r_rd_addr   <= rd_addr;
            r_rd_write  <= rd_write;
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign in_ready      = w_in_ready;
   assign out_valid     = r_valid;
   assign out_inst      = r_inst;
   assign out_pc_plus_4 = r_pc_plus_4;
   assign out_imm       = r_imm;
   assign out_rd_addr   = r_rd_addr;
   assign out_rd_write  = r_rd_write;
   assign pending       = r_pending;

`ifdef DECODE_PERF_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_drain && r_perf_issued != 32'hFFFF_FFFF) r_perf_issued <= r_perf_issued + 32'd1;
         if (in_valid && w_hazard && !flush && r_perf_stall != 32'hFFFF_FFFF)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_issued = r_perf_issued;
   assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed vectors, a spec-level model checked every negedge, literal pins.
module tb_decode_issue_stage;
   localparam int XLEN  = 36;
   localparam int NREGS = 32;
   localparam int RA    = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      inst;
   logic [XLEN-1:0]  pc_plus_4;
   logic [3:0]       imm_type;
   logic [RA-1:0]    rs1_addr, rs2_addr, rd_addr;
   logic             rs1_used, rs2_used, rd_write;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_inst;
   logic [XLEN-1:0]  out_pc_plus_4;
   logic [XLEN-1:0]  out_imm;
   logic [RA-1:0]    out_rd_addr;
   logic             out_rd_write;
   logic             wb_valid;
   logic [RA-1:0]    wb_addr;
   logic             flush;
   logic [NREGS-1:0] pending;
`ifdef DECODE_PERF_EN
   logic [31:0]      perf_issued, perf_stall;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode_issue_stage #(.XLEN(XLEN), .NREGS(NREGS), .IMM_TYPES(9)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
      .pc_plus_4(pc_plus_4), .imm_type(imm_type), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd_addr(rd_addr), .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_write(rd_write),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc_plus_4(out_pc_plus_4), .out_imm(out_imm), .out_rd_addr(out_rd_addr),
      .out_rd_write(out_rd_write), .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
      .pending(pending)
`ifdef DECODE_PERF_EN
      , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit              m_valid, n_valid;
   logic [31:0]     m_inst, n_inst;
   logic [XLEN-1:0] m_pc, n_pc, m_imm, n_imm;
   int              m_rd, n_rd;
   bit              m_rdw, n_rdw;
   bit              m_pend[NREGS];
   bit              n_pend[NREGS];
   longint          m_issued, n_issued, m_stall, n_stall;

   // Field value and width per format, then two's-complement interpretation by arithmetic.
   function automatic logic [XLEN-1:0] model_imm(input logic [31:0] i, input int t);
      longint v;
      int     w;
      longint hi5;
      v = 0; w = 0;
      hi5 = longint'((i >> 20) & 32'd31);
      case (t)
         0: begin v = longint'(i & 32'h01FF_FFFF); w = 0; end
         1: begin v = hi5 * 65536 + longint'(i & 32'hFFFF); w = 21; end
         2: begin v = longint'(i & 32'h003F_FFFF); w = 22; end
         3: begin v = longint'(i & 32'h7FFF); w = 15; end
         4: begin v = longint'(i & 32'h7_FFFF); w = 19; end
         5: begin v = hi5 * 1024 + longint'(i & 32'h3FF); w = 15; end
         6: begin v = longint'((i >> 4) & 32'h7FF); w = 11; end
         7: begin v = hi5 * 2048 + longint'((i >> 4) & 32'h7FF); w = 16; end
         8: begin v = hi5 * 64 + longint'((i >> 4) & 32'h3F); w = 11; end
         default: begin v = 0; w = 0; end
      endcase
      if (w > 0 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
      return v[XLEN-1:0];
   endfunction

   function automatic bit m_busy(input int r);
      return (m_pend[r] && !(wb_valid && int'(wb_addr) == r)) || (m_valid && m_rdw && m_rd == r);
   endfunction

   always @(negedge clk) begin
      bit               h, rdy, acc, drn;
      logic [NREGS-1:0] pv;
      if (rst_n) begin
         h = (rs1_used && m_busy(int'(rs1_addr))) || (rs2_used && m_busy(int'(rs2_addr))) ||
             (rd_write && m_busy(int'(rd_addr)));
         rdy = !flush && !h && (!m_valid || out_ready);
         for (int i = 0; i < NREGS; i++) pv[i] = m_pend[i];
         chk("m_in_ready", 64'(in_ready), 64'(rdy));
         chk("m_out_valid", 64'(out_valid), 64'(m_valid));
         chk("m_out_inst", 64'(out_inst), 64'(m_inst));
         chk("m_out_pc", 64'(out_pc_plus_4), 64'(m_pc));
         chk("m_out_imm", 64'(out_imm), 64'(m_imm));
         chk("m_out_rd", 64'(out_rd_addr), 64'(m_rd));
         chk("m_out_rdw", 64'(out_rd_write), 64'(m_rdw));
         chk("m_pending", 64'(pending), 64'(pv));
`ifdef DECODE_PERF_EN
         chk("m_perf_issued", 64'(perf_issued), 64'(m_issued));
         chk("m_perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
         acc = in_valid && rdy;
         drn = m_valid && out_ready && !flush;
         n_pend = m_pend;
         if (wb_valid) n_pend[wb_addr] = 1'b0;
         if (drn && m_rdw) n_pend[m_rd] = 1'b1;
         n_valid = m_valid; n_inst = m_inst; n_pc = m_pc; n_imm = m_imm; n_rd = m_rd; n_rdw = m_rdw;
         if (flush) n_valid = 0;
         else if (acc) begin
            n_valid = 1; n_inst = inst; n_pc = pc_plus_4; n_imm = model_imm(inst, int'(imm_type));
            n_rd = int'(rd_addr); n_rdw = rd_write;
         end else if (drn) n_valid = 0;
         n_issued = (drn && m_issued < 64'hFFFF_FFFF) ? m_issued + 1 : m_issued;
         n_stall  = (in_valid && h && !flush && m_stall < 64'hFFFF_FFFF) ? m_stall + 1 : m_stall;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 0; m_inst = '0; m_pc = '0; m_imm = '0; m_rd = 0; m_rdw = 0;
         n_valid = 0; n_inst = '0; n_pc = '0; n_imm = '0; n_rd = 0; n_rdw = 0;
         for (int i = 0; i < NREGS; i++) begin m_pend[i] = 0; n_pend[i] = 0; end
         m_issued = 0; n_issued = 0; m_stall = 0; n_stall = 0;
      end else begin
         m_valid = n_valid; m_inst = n_inst; m_pc = n_pc; m_imm = n_imm; m_rd = n_rd; m_rdw = n_rdw;
         m_pend = n_pend; m_issued = n_issued; m_stall = n_stall;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] it,
                        input int r1, input logic u1, input int r2, input logic u2,
                        input int rd, input logic w);
      in_valid = v; inst = ins; imm_type = it;
      rs1_addr = RA'(r1); rs1_used = u1; rs2_addr = RA'(r2); rs2_used = u2;
      rd_addr = RA'(rd); rd_write = w;
      pc_plus_4 = pc_plus_4 + 36'd4;
   endtask

   logic [31:0] vec_inst[4];
   logic [31:0] held;

   initial begin
      vec_inst[0] = 32'hFFFF_FFFF; vec_inst[1] = 32'h0123_4567;
      vec_inst[2] = 32'h0080_0210; vec_inst[3] = 32'h0A5A_5A5A;
      rst_n = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
      pc_plus_4 = 36'h8_0000_0000;
      drive(0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_pending", 64'(pending), 64'd0);
      chk("reset_out_imm", 64'(out_imm), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // immediates
      drive(1, 32'h01F0_8000, 4'd1, 0, 0, 0, 0, 0, 0); tick();
      chk("imm_type1", 64'(out_imm), 64'h0000_000F_FFFF_8000);
      chk("imm_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      drive(1, 32'h01F0_8000, 4'd12, 0, 0, 0, 0, 0, 0); tick();
      chk("imm_type12", 64'(out_imm), 64'd0);
      drive(1, 32'hFFFF_FFFF, 4'd0, 0, 0, 0, 0, 0, 0); tick();
      chk("imm_type0_zext", 64'(out_imm), 64'h0000_0000_01FF_FFFF);
      drive(1, 32'h0000_4000, 4'd6, 0, 0, 0, 0, 0, 0); tick();
      chk("imm_type6", 64'(out_imm), 64'h0000_000F_FFFF_FC00);
      for (int t = 0; t < 16; t++)
         for (int k = 0; k < 4; k++) begin
            drive(1, vec_inst[k], 4'(t), 0, 0, 0, 0, 0, 0); tick();
         end
      in_valid = 1'b0; tick();

      // RAW through the slot, then through the scoreboard
      out_ready = 1'b0;
      drive(1, 32'h1111_0000, 4'd2, 0, 0, 0, 0, 5, 1); tick();
      drive(1, 32'h2222_0000, 4'd3, 5, 1, 0, 0, 1, 0); #1;
      chk("raw_slot_stall", 64'(in_ready), 64'd0);
      tick(); tick();
      out_ready = 1'b1; #1;
      chk("raw_drain_stall", 64'(in_ready), 64'd0);
      tick();
      chk("raw_pending5", 64'(pending[5]), 64'd1);
      chk("raw_pend_stall", 64'(in_ready), 64'd0);
      wb_valid = 1'b1; wb_addr = 5'd5; #1;
      chk("raw_wb_bypass", 64'(in_ready), 64'd1);
      tick();
      wb_valid = 1'b0;
      chk("raw_issued", 64'(out_inst), 64'h2222_0000);
      chk("raw_cleared", 64'(pending), 64'd0);
      in_valid = 1'b0; tick();

      // rs == rd of the same instruction
      drive(1, 32'h5555_0000, 4'd7, 4, 1, 4, 1, 4, 1); #1;
      chk("self_rs_rd", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0; tick();
      wb_valid = 1'b1; wb_addr = 5'd4; tick(); wb_valid = 1'b0;

      // WAW
      drive(1, 32'h3333_0000, 4'd4, 0, 0, 0, 0, 7, 1); tick();
      in_valid = 1'b0; tick();
      chk("waw_pending7", 64'(pending[7]), 64'd1);
      drive(1, 32'h4444_0000, 4'd5, 0, 0, 0, 0, 7, 1); #1;
      chk("waw_stall", 64'(in_ready), 64'd0);
      tick();
      wb_valid = 1'b1; wb_addr = 5'd7; tick(); wb_valid = 1'b0;
      chk("waw_accept_rd", 64'(out_rd_addr), 64'd7);
      chk("waw_accept_inst", 64'(out_inst), 64'h4444_0000);
      in_valid = 1'b0; tick();
      wb_valid = 1'b1; wb_addr = 5'd7; tick(); wb_valid = 1'b0;

      // backpressure then full-rate streaming
      out_ready = 1'b0;
      drive(1, 32'h6000_0001, 4'd8, 1, 1, 2, 1, 10, 0); tick();
      held = out_inst;
      drive(1, 32'h6000_0002, 4'd8, 1, 1, 2, 1, 11, 0);
      for (int c = 0; c < 3; c++) begin
         #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("bp_stable", 64'(out_inst), 64'(held));
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1, 32'h6000_0010 + 32'(k), 4'd8, 0, 0, 0, 0, 0, 0); tick();
         chk("stream_inst", 64'(out_inst), 64'(32'h6000_0010 + 32'(k)));
      end
      in_valid = 1'b0; tick();

      // flush
      out_ready = 1'b0;
      drive(1, 32'h7000_0000, 4'd3, 0, 0, 0, 0, 3, 1); tick();
      drive(1, 32'h7000_0004, 4'd3, 0, 0, 0, 0, 0, 0);
      flush = 1'b1; out_ready = 1'b1; #1;
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_kill", 64'(out_valid), 64'd0);
      chk("flush_no_set", 64'(pending[3]), 64'd0);
      tick();

      // set/clear collision on r9, then a no-op writeback
      drive(1, 32'h7100_0000, 4'd3, 0, 0, 0, 0, 9, 1); tick();
      in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd9; tick();
      wb_valid = 1'b0;
      chk("set_wins_r9", 64'(pending[9]), 64'd1);
      wb_valid = 1'b1; wb_addr = 5'd9; tick();
      wb_addr = 5'd12; tick(); wb_valid = 1'b0;
      chk("wb_noop", 64'(pending), 64'd0);

      // async reset in the middle of a stall
      drive(1, 32'h8000_0005, 4'd2, 0, 0, 0, 0, 5, 1); tick();
      drive(1, 32'h8000_0008, 4'd2, 0, 0, 0, 0, 8, 1); tick();
      drive(1, 32'h8000_0002, 4'd2, 0, 0, 0, 0, 2, 1); tick();
      out_ready = 1'b0;
      drive(1, 32'h8000_00FF, 4'd2, 5, 1, 0, 0, 0, 0); tick();
      chk("pre_rst_pending", 64'(pending), 64'h0000_0120);
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      chk("pre_rst_stall", 64'(in_ready), 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      chk("rst_out_pc", 64'(out_pc_plus_4), 64'd0);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      chk("rst_out_rd", 64'({out_rd_write, out_rd_addr}), 64'd0);
`ifdef DECODE_PERF_EN
      chk("rst_perf", 64'({perf_issued, perf_stall}), 64'd0);
`endif
      drive(0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
